// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package sub_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-step operation still needs a one-bit counter.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor built from primitive gates: d = a-b-bin, bout = borrow out.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb_s;
    logic na_s;
    logic naxb_s;
    logic t0_s;
    logic t1_s;

    xor g_axb  (axb_s, a, b);
    xor g_d    (d, axb_s, bin);
    not g_na   (na_s, a);
    not g_naxb (naxb_s, axb_s);
    and g_t0   (t0_s, na_s, b);
    and g_t1   (t1_s, naxb_s, bin);
    or  g_bout (bout, t0_s, t1_s);

endmodule

// File: rtl/serial_sub_8bit.sv
// Bit-serial subtractor: Dout = Ain - Bin - Bi, processed LSB first through one
// full-subtractor cell, with a start/busy/done handshake.
module serial_sub_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Dout,
    output logic             Bo
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] dout_r;
    logic             bo_r;

    logic             d_s;
    logic             bout_s;
    logic             accept_s;
    logic             last_s;

    serial_sub_cell u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Requests are only taken outside RUN, so a start while busy is ignored.
    assign accept_s = start && (state_r != ST_RUN);
    assign last_s   = (state_r == ST_RUN) && (cnt_r == CNT_LAST);

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus busy/done, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand shift registers, borrow chain, partial result and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            a_r      <= Ain;
            b_r      <= Bin;
            borrow_r <= Bi;
            cnt_r    <= '0;
        end else if (state_r == ST_RUN) begin
            a_r      <= {1'b0, a_r[WIDTH-1:1]};
            b_r      <= {1'b0, b_r[WIDTH-1:1]};
            res_r    <= {d_s, res_r[WIDTH-1:1]};
            borrow_r <= bout_s;
            cnt_r    <= cnt_r + CNT_ONE;
        end else begin
            a_r      <= a_r;
            b_r      <= b_r;
            res_r    <= res_r;
            borrow_r <= borrow_r;
            cnt_r    <= cnt_r;
        end
    end

    // Visible result changes only on the final step, so Dout/Bo hold during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
            bo_r   <= 1'b0;
        end else if (last_s) begin
            dout_r <= {d_s, res_r[WIDTH-1:1]};
            bo_r   <= bout_s;
        end else begin
            dout_r <= dout_r;
            bo_r   <= bo_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Dout = dout_r;
    assign Bo   = bo_r;

endmodule

// File: tb/tb_serial_sub_8bit.sv
// Self-checking bench for serial_sub_8bit: directed scenarios plus random
// operands against an arithmetic reference {Bo,Dout} = Ain - Bin - Bi.
module tb_serial_sub_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] Ain;
    logic [7:0] Bin;
    logic       Bi;
    logic       busy;
    logic       done;
    logic [7:0] Dout;
    logic       Bo;

    int checks = 0;
    int errors = 0;

    serial_sub_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Ain   (Ain),
        .Bin   (Bin),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .Dout  (Dout),
        .Bo    (Bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int diff;
        diff = int'(a) - int'(b) - int'(bi);
        return 9'(diff);
    endfunction

    // Called at a negedge. Starts one operation and waits (bounded) for done.
    // side_ok: busy high and Dout/Bo stable on every cycle before done, busy low at done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input bit noise, output logic [7:0] dout, output logic bo,
                          output int lat, output bit side_ok);
        logic [7:0] hold_d;
        logic       hold_b;
        hold_d  = Dout;
        hold_b  = Bo;
        start   = 1'b1;
        Ain     = a;
        Bin     = b;
        Bi      = bi;
        lat     = 0;
        dout    = 8'h00;
        bo      = 1'b0;
        side_ok = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat  = n;
                dout = Dout;
                bo   = Bo;
                if (busy !== 1'b0) side_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1 || Dout !== hold_d || Bo !== hold_b) side_ok = 1'b0;
            if (noise) begin
                Ain = 8'($urandom);
                Bin = 8'($urandom);
                Bi  = 1'($urandom);
                if (n <= 7) start = 1'($urandom);
            end
        end
        start = 1'b0;
        if (lat == 0) lat = 99;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        Ain   = 8'h00;
        Bin   = 8'h00;
        Bi    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Dout !== 8'h00 || Bo !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b Dout=%h Bo=%b want 0 0 00 0", busy, done, Dout, Bo);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       b;
        int         lat;
        bit         ok;
        run_op(8'h5A, 8'h21, 1'b0, 1'b0, d, b, lat, ok);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        checks++;
        if (d !== 8'h39 || b !== 1'b0) begin
            errors++;
            $display("FAIL basic_5A_21 got Dout=%h Bo=%b want 39 0", d, b);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_busy_hold got bad busy/hold want busy=1 and stable outputs in RUN");
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || Dout !== 8'h39 || Bo !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b Dout=%h Bo=%b want 0 39 0", done, Dout, Bo);
        end
        run_op(8'h00, 8'h01, 1'b0, 1'b0, d, b, lat, ok);
        checks++;
        if (d !== 8'hFF || b !== 1'b1 || lat != 9) begin
            errors++;
            $display("FAIL basic_00_01 got Dout=%h Bo=%b lat=%0d want FF 1 9", d, b, lat);
        end
    endtask

    task automatic test_borrow_in();
        logic [7:0] d;
        logic       b;
        int         lat;
        bit         ok;
        @(negedge clk);
        run_op(8'h80, 8'h7F, 1'b1, 1'b0, d, b, lat, ok);
        checks++;
        if (d !== 8'h00 || b !== 1'b0) begin
            errors++;
            $display("FAIL bi_80_7F got Dout=%h Bo=%b want 00 0", d, b);
        end
        @(negedge clk);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, d, b, lat, ok);
        checks++;
        if (d !== 8'hFF || b !== 1'b1) begin
            errors++;
            $display("FAIL bi_FF_FF got Dout=%h Bo=%b want FF 1", d, b);
        end
    endtask

    task automatic test_start_busy();
        int         dones;
        int         first;
        logic [7:0] d;
        logic       b;
        @(negedge clk);
        start = 1'b1;
        Ain   = 8'h10;
        Bin   = 8'h01;
        Bi    = 1'b0;
        @(posedge clk);
        dones = 0;
        first = 0;
        d     = 8'h00;
        b     = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first == 0) begin
                    first = n;
                    d     = Dout;
                    b     = Bo;
                end
            end
            if (n == 3) begin
                start = 1'b1;
                Ain   = 8'hAA;
                Bin   = 8'h55;
                Bi    = 1'b1;
            end
        end
        checks++;
        if (dones != 1 || first != 9) begin
            errors++;
            $display("FAIL busy_ignore_count got dones=%0d first=%0d want 1 9", dones, first);
        end
        checks++;
        if (d !== 8'h0F || b !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_result got Dout=%h Bo=%b want 0F 0", d, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       b;
        int         lat;
        bit         ok;
        @(negedge clk);
        run_op(8'h20, 8'h10, 1'b0, 1'b0, d, b, lat, ok);
        checks++;
        if (d !== 8'h10 || b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got Dout=%h Bo=%b want 10 0", d, b);
        end
        run_op(8'h03, 8'h05, 1'b0, 1'b0, d, b, lat, ok);
        checks++;
        if (d !== 8'hFE || b !== 1'b1 || lat != 9 || !ok) begin
            errors++;
            $display("FAIL b2b_second got Dout=%h Bo=%b lat=%0d ok=%0d want FE 1 9 1", d, b, lat, ok);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start = 1'b1;
        Ain   = 8'h77;
        Bin   = 8'h11;
        Bi    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Dout !== 8'h00 || Bo !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b Dout=%h Bo=%b want 0 0 00 0", busy, done, Dout, Bo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (14) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic [8:0] exp;
        int         lat;
        bit         ok;
        int         bad;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bi  = 1'($urandom);
            exp = ref_sub(a, b, bi);
            run_op(a, b, bi, 1'b1, d, bo, lat, ok);
            checks++;
            if ({bo, d} !== exp || lat != 9 || !ok) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d %h-%h-%b got Bo=%b Dout=%h lat=%0d ok=%0d want Bo=%b Dout=%h lat=9",
                             i, a, b, bi, bo, d, lat, ok, exp[8], exp[7:0]);
            end
            if (($urandom & 32'd3) != 32'd0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_in();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
